// File: rtl/video_dram_pkg.sv
// Shared types and default timing for the video DRAM strobe sequencer.
// Phase state, access owner and counter-sizing helpers live here.
package video_dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        CASP,
        PRE,
        REFR
    } state_e;

    typedef enum logic [1:0] {
        OWN_CPU,
        OWN_VID,
        OWN_REF
    } owner_e;

    localparam int T_RCD_DEF        = 2;
    localparam int T_CAS_DEF        = 2;
    localparam int T_RP_DEF         = 2;
    localparam int T_RAS_REF_DEF    = 3;
    localparam int REF_INTERVAL_DEF = 156;
    localparam int ROW_BITS_DEF     = 7;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // A counter that is loaded with v-1 and counts down needs $clog2(v) bits, at least one.
    function automatic int cnt_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/video_dram_refresh_timer.sv
// Refresh interval down-counter, single-bit pending flag and refresh row address.
// A tick that lands while a refresh is already pending is absorbed.
module video_dram_refresh_timer
    import video_dram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int ROW_BITS     = ROW_BITS_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_grant,
    input  logic                i_row_done,
    output logic                o_pending,
    output logic [ROW_BITS-1:0] o_rfsh_addr
);

    localparam int            TW     = cnt_w(REF_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(REF_INTERVAL - 1);

    logic [TW-1:0]       r_tcnt;
    logic                r_pending;
    logic [ROW_BITS-1:0] r_addr;
    logic                w_tick;

    assign w_tick = (r_tcnt == '0);

    // A tick wins over a same-edge grant so the new interval is not lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt    <= RELOAD;
            r_pending <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_tcnt <= w_tick ? RELOAD : r_tcnt - 1'b1;
            if (w_tick)
                r_pending <= 1'b1;
            else if (i_grant)
                r_pending <= 1'b0;
            if (i_row_done)
                r_addr <= r_addr + 1'b1;
        end
    end

    assign o_pending   = r_pending;
    assign o_rfsh_addr = r_addr;

endmodule

// File: rtl/video_dram_timing_sequencer.sv
// Shared RAS/CAS/WE/MUX strobe sequencer for the video DRAM banks: arbitrates
// refresh, video fetch and CPU access, and holds the CPU off through WAIT_AL.
module video_dram_timing_sequencer
    import video_dram_pkg::*;
#(
    parameter int T_RCD        = T_RCD_DEF,
    parameter int T_CAS        = T_CAS_DEF,
    parameter int T_RP         = T_RP_DEF,
    parameter int T_RAS_REF    = T_RAS_REF_DEF,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int ROW_BITS     = ROW_BITS_DEF
) (
    input  logic                CLK,
    input  logic                RESET_AL,
    input  logic                CPU_REQ_AL,
    input  logic                MW_AL,
    input  logic                VID_REQ,
    output logic                VID_ACK,
    output logic                RAS,
    output logic                CAS,
    output logic                WE,
    output logic                MUX,
    output logic                REF,
    output logic [ROW_BITS-1:0] RFSH_ADDR,
    output logic                WAIT_AL
);

    localparam int            CW         = cnt_w(max4(T_RCD, T_CAS, T_RP, T_RAS_REF));
    localparam logic [CW-1:0] LD_RCD     = CW'(T_RCD - 1);
    localparam logic [CW-1:0] LD_CAS     = CW'(T_CAS - 1);
    localparam logic [CW-1:0] LD_RP      = CW'(T_RP - 1);
    localparam logic [CW-1:0] LD_RAS_REF = CW'(T_RAS_REF - 1);

    state_e        r_state, w_next_state;
    owner_e        r_owner, w_next_owner;
    logic [CW-1:0] r_cnt, w_next_cnt;
    logic          r_wr, w_next_wr;
    logic          r_served;
    logic          r_ras, r_cas, r_we, r_mux, r_ref, r_ack;
    logic          w_pending, w_grant_ref, w_row_done, w_last_cpu_cas;

    video_dram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL),
        .ROW_BITS    (ROW_BITS)
    ) u_refresh (
        .i_clk      (CLK),
        .i_rst_n    (RESET_AL),
        .i_grant    (w_grant_ref),
        .i_row_done (w_row_done),
        .o_pending  (w_pending),
        .o_rfsh_addr(RFSH_ADDR)
    );

    // Grants are only taken in IDLE; each phase reloads its counter and counts down to 0.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_owner = r_owner;
        w_next_wr    = r_wr;
        w_grant_ref  = 1'b0;
        w_row_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pending) begin
                    w_next_state = REFR;
                    w_next_cnt   = LD_RAS_REF;
                    w_next_owner = OWN_REF;
                    w_next_wr    = 1'b0;
                    w_grant_ref  = 1'b1;
                end else if (VID_REQ) begin
                    w_next_state = ROW;
                    w_next_cnt   = LD_RCD;
                    w_next_owner = OWN_VID;
                    w_next_wr    = 1'b0;
                end else if (!CPU_REQ_AL && !r_served) begin
                    w_next_state = ROW;
                    w_next_cnt   = LD_RCD;
                    w_next_owner = OWN_CPU;
                    w_next_wr    = ~MW_AL;
                end
            end
            ROW: begin
                if (r_cnt == '0) begin
                    w_next_state = COL;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            COL: begin
                w_next_state = CASP;
                w_next_cnt   = LD_CAS;
            end
            CASP: begin
                if (r_cnt == '0) begin
                    w_next_state = PRE;
                    w_next_cnt   = LD_RP;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            PRE: begin
                if (r_cnt == '0)
                    w_next_state = IDLE;
                else
                    w_next_cnt = r_cnt - 1'b1;
            end
            REFR: begin
                if (r_cnt == '0) begin
                    w_next_state = PRE;
                    w_next_cnt   = LD_RP;
                    w_row_done   = 1'b1;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign w_last_cpu_cas = (r_state == CASP) && (r_cnt == '0) && (r_owner == OWN_CPU);

    always_ff @(posedge CLK or negedge RESET_AL) begin
        if (!RESET_AL) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_owner  <= OWN_CPU;
            r_wr     <= 1'b0;
            r_served <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_owner <= w_next_owner;
            r_wr    <= w_next_wr;
            if (w_last_cpu_cas)
                r_served <= 1'b1;
            else if (CPU_REQ_AL)
                r_served <= 1'b0;
        end
    end

    // Strobes are registered from the next state so they line up with r_state cycle for cycle.
    always_ff @(posedge CLK or negedge RESET_AL) begin
        if (!RESET_AL) begin
            r_ras <= 1'b0;
            r_cas <= 1'b0;
            r_we  <= 1'b0;
            r_mux <= 1'b0;
            r_ref <= 1'b0;
            r_ack <= 1'b0;
        end else begin
            r_ras <= (w_next_state == ROW) || (w_next_state == COL) ||
                     (w_next_state == CASP) || (w_next_state == REFR);
            r_mux <= (w_next_state == COL) || (w_next_state == CASP);
            r_cas <= (w_next_state == CASP);
            r_we  <= (w_next_state == CASP) && w_next_wr;
            r_ref <= (w_next_state == REFR);
            r_ack <= (w_next_state == CASP) && (w_next_cnt == '0) && (w_next_owner == OWN_VID);
        end
    end

    assign RAS     = r_ras;
    assign CAS     = r_cas;
    assign WE      = r_we;
    assign MUX     = r_mux;
    assign REF     = r_ref;
    assign VID_ACK = r_ack;
    assign WAIT_AL = ~(RESET_AL & ~CPU_REQ_AL & ~r_served & ~w_last_cpu_cas);

endmodule

// File: tb/tb_video_dram_timing_sequencer.sv
// Scoreboard bench: a waveform-template reference model pushes the expected
// outputs of every cycle; a negedge monitor pops and compares them.
module tb_video_dram_timing_sequencer;

    localparam int T_RCD     = 2;
    localparam int T_CAS     = 2;
    localparam int T_RP      = 2;
    localparam int T_RAS_REF = 3;
    localparam int R         = 16;
    localparam int RB        = 7;
    localparam int MLEN      = T_RCD + 1 + T_CAS + T_RP;
    localparam int LAST_CAS  = T_RCD + T_CAS;
    localparam int RLEN      = T_RAS_REF + T_RP;

    logic          CLK        = 1'b0;
    logic          RESET_AL   = 1'b0;
    logic          CPU_REQ_AL = 1'b1;
    logic          MW_AL      = 1'b1;
    logic          VID_REQ    = 1'b0;
    logic          VID_ACK, RAS, CAS, WE, MUX, REF, WAIT_AL;
    logic [RB-1:0] RFSH_ADDR;

    video_dram_timing_sequencer #(
        .T_RCD       (T_RCD),
        .T_CAS       (T_CAS),
        .T_RP        (T_RP),
        .T_RAS_REF   (T_RAS_REF),
        .REF_INTERVAL(R),
        .ROW_BITS    (RB)
    ) dut (
        .CLK       (CLK),
        .RESET_AL  (RESET_AL),
        .CPU_REQ_AL(CPU_REQ_AL),
        .MW_AL     (MW_AL),
        .VID_REQ   (VID_REQ),
        .VID_ACK   (VID_ACK),
        .RAS       (RAS),
        .CAS       (CAS),
        .WE        (WE),
        .MUX       (MUX),
        .REF       (REF),
        .RFSH_ADDR (RFSH_ADDR),
        .WAIT_AL   (WAIT_AL)
    );

    always #5 CLK = ~CLK;

    // strb = {RAS,CAS,WE,MUX,REF,VID_ACK}; blk = CPU already served or in its last CAS cycle
    typedef struct packed {
        logic [5:0]    strb;
        logic [RB-1:0] addr;
        logic          blk;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: an access is a fixed waveform indexed by its offset since grant.
    int m_n, m_kind, m_off, m_addr;
    bit m_act, m_wr, m_pend, m_served;

    always @(posedge CLK) begin : model
        exp_t e;
        bit   tick, clr, sset;
        bit   ras, cas, we, mux, rf, ack;
        if (!RESET_AL) begin
            m_n = 0; m_act = 0; m_kind = 0; m_off = 0; m_wr = 0;
            m_pend = 0; m_served = 0; m_addr = 0;
        end else begin
            clr  = 0;
            sset = 0;
            m_n  = m_n + 1;
            tick = (m_n % R) == 0;
            if (m_act) begin
                if (m_kind == 2 && m_off == T_RAS_REF - 1) m_addr = (m_addr + 1) % (1 << RB);
                if (m_kind == 0 && m_off == LAST_CAS) sset = 1;
                if (m_off == ((m_kind == 2) ? RLEN : MLEN) - 1) m_act = 0;
                else m_off = m_off + 1;
            end else if (m_pend) begin
                m_act = 1; m_kind = 2; m_off = 0; m_wr = 0; clr = 1;
            end else if (VID_REQ) begin
                m_act = 1; m_kind = 1; m_off = 0; m_wr = 0;
            end else if (!CPU_REQ_AL && !m_served) begin
                m_act = 1; m_kind = 0; m_off = 0; m_wr = !MW_AL;
            end
            if (sset) m_served = 1;
            else if (CPU_REQ_AL) m_served = 0;
            if (tick) m_pend = 1;
            else if (clr) m_pend = 0;
        end
        ras = 0; cas = 0; we = 0; mux = 0; rf = 0; ack = 0;
        if (m_act && m_kind != 2) begin
            ras = (m_off <= LAST_CAS);
            mux = (m_off >= T_RCD) && (m_off <= LAST_CAS);
            cas = (m_off > T_RCD) && (m_off <= LAST_CAS);
            we  = cas && m_wr;
            ack = (m_kind == 1) && (m_off == LAST_CAS);
        end else if (m_act) begin
            ras = (m_off < T_RAS_REF);
            rf  = ras;
        end
        e.strb = {ras, cas, we, mux, rf, ack};
        e.addr = RB'(m_addr);
        e.blk  = m_served || (m_act && m_kind == 0 && m_off == LAST_CAS);
        q.push_back(e);
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        logic ew;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (!RESET_AL) begin
                e.strb = '0;
                e.addr = '0;
                ew     = 1'b1;
            end else begin
                ew = ~(~CPU_REQ_AL & ~e.blk);
            end
            n_cmp++;
            if ({RAS, CAS, WE, MUX, REF, VID_ACK, RFSH_ADDR, WAIT_AL} !== {e.strb, e.addr, ew}) begin
                n_bad++;
                $display("FAIL outputs t=%0t ras/cas/we/mux/ref/ack got %b need %b, addr got %0d need %0d, wait_al got %b need %b",
                         $time, {RAS, CAS, WE, MUX, REF, VID_ACK}, e.strb, RFSH_ADDR, e.addr, WAIT_AL, ew);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (VID_ACK) VID_REQ = 1'b0;
    endtask

    task automatic wait_release(input string tag);
        int k;
        k = 0;
        while (!WAIT_AL && k < 80) begin
            step();
            k++;
        end
        if (!WAIT_AL) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: WAIT_AL got %b need 1", tag, WAIT_AL);
        end
    endtask

    task automatic cpu_access(input bit wr, input int hold);
        CPU_REQ_AL = 1'b0;
        MW_AL      = ~wr;
        step();
        wait_release(wr ? "cpu_write" : "cpu_read");
        repeat (hold) step();
        CPU_REQ_AL = 1'b1;
        MW_AL      = 1'b1;
    endtask

    initial begin : stim
        int k;
        repeat (3) @(posedge CLK);
        #2 RESET_AL = 1'b1;
        repeat (4) step();

        cpu_access(1'b0, 6);
        repeat (3) step();
        cpu_access(1'b1, 0);
        repeat (3) step();

        VID_REQ    = 1'b1;
        CPU_REQ_AL = 1'b0;
        MW_AL      = 1'b1;
        step();
        wait_release("vid_then_cpu");
        CPU_REQ_AL = 1'b1;
        repeat (4) step();

        CPU_REQ_AL = 1'b0;
        MW_AL      = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!(CAS && WE) && k < 60);
        if (!(CAS && WE)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cpu_write_casp timeout: CAS/WE got %b%b need 11", CAS, WE);
        end
        RESET_AL = 1'b0;
        step();
        step();
        #1 RESET_AL = 1'b1;
        step();
        wait_release("cpu_after_reset");
        CPU_REQ_AL = 1'b1;
        MW_AL      = 1'b1;
        step();

        for (int i = 0; i < 1200; i++) begin
            step();
            if (CPU_REQ_AL && $urandom_range(0, 9) == 0) begin
                CPU_REQ_AL = 1'b0;
                MW_AL      = 1'($urandom_range(0, 1));
            end else if (!CPU_REQ_AL && WAIT_AL && $urandom_range(0, 2) == 0) begin
                CPU_REQ_AL = 1'b1;
                MW_AL      = 1'($urandom_range(0, 1));
            end
            if (!VID_REQ && $urandom_range(0, 11) == 0) VID_REQ = 1'b1;
        end

        CPU_REQ_AL = 1'b1;
        k = 0;
        while (VID_REQ && k < 80) begin
            step();
            k++;
        end
        if (VID_REQ) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vid_drain timeout: VID_ACK never seen, VID_REQ got %b need 0", VID_REQ);
            VID_REQ = 1'b0;
        end
        repeat (1300) step();
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
